// File: rtl/lua_cpu_pkg.sv
// lua_cpu_pkg: definitions shared by the decoder, sequencer and operand fetch.
//   - TValue layout in memory (TV_STRIDE bytes: value word, then tt_ word)
//   - ISK_BIT: bit of a decoded B/C field that selects the constant table
//   - Lua type tags and opcode numbers
//   - Operand-fetch state encoding plus a helper that picks the next operand state
package lua_cpu_pkg;

    localparam int unsigned TV_STRIDE = 8;
    localparam int unsigned ISK_BIT   = 8;

    // Type tags (tt_)
    localparam logic [5:0] T_NIL      = 6'd0;
    localparam logic [5:0] T_BOOLEAN  = 6'd1;
    localparam logic [5:0] T_NUMBER   = 6'd3;
    localparam logic [5:0] T_STRING   = 6'd4;
    localparam logic [5:0] T_TABLE    = 6'd5;
    localparam logic [5:0] T_FUNCTION = 6'd6;

    // Opcodes (shared with the sequencer)
    localparam logic [5:0] OP_MOVE     = 6'd0,  OP_LOADK    = 6'd1,  OP_LOADBOOL = 6'd2;
    localparam logic [5:0] OP_LOADNIL  = 6'd3,  OP_GETUPVAL = 6'd4,  OP_GETGLOBAL = 6'd5;
    localparam logic [5:0] OP_GETTABLE = 6'd6,  OP_SETGLOBAL = 6'd7, OP_SETUPVAL = 6'd8;
    localparam logic [5:0] OP_SETTABLE = 6'd9,  OP_NEWTABLE = 6'd10, OP_SELF     = 6'd11;
    localparam logic [5:0] OP_ADD      = 6'd12, OP_SUB      = 6'd13, OP_MUL      = 6'd14;
    localparam logic [5:0] OP_DIV      = 6'd15, OP_MOD      = 6'd16, OP_POW      = 6'd17;
    localparam logic [5:0] OP_UNM      = 6'd18, OP_NOT      = 6'd19, OP_LEN      = 6'd20;
    localparam logic [5:0] OP_CONCAT   = 6'd21, OP_JMP      = 6'd22, OP_EQ       = 6'd23;
    localparam logic [5:0] OP_LT       = 6'd24, OP_LE       = 6'd25, OP_TEST     = 6'd26;
    localparam logic [5:0] OP_TESTSET  = 6'd27, OP_CALL     = 6'd28, OP_TAILCALL = 6'd29;
    localparam logic [5:0] OP_RETURN   = 6'd30, OP_FORLOOP  = 6'd31, OP_FORPREP  = 6'd32;
    localparam logic [5:0] OP_TFORLOOP = 6'd33, OP_SETLIST  = 6'd34, OP_CLOSE    = 6'd35;
    localparam logic [5:0] OP_CLOSURE  = 6'd36, OP_VARARG   = 6'd37;

    // Operand-fetch states; A states only reachable when the A operand is built in
    typedef enum logic [2:0] {
        StIdle,
        StAVal,
        StATt,
        StBVal,
        StBTt,
        StCVal,
        StCTt,
        StDone
    } of_state_e;

    // First value-read state among the operands still required, in A, B, C order
    function automatic of_state_e of_first_state(input logic need_a, input logic need_b,
                                                 input logic need_c);
        if (need_a) return StAVal;
        if (need_b) return StBVal;
        if (need_c) return StCVal;
        return StDone;
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: Avalon-MM read-only master bus used by operand_fetch.
//   mem_address     32  word address driven by the master (0 when not reading)
//   mem_read         1  read strobe
//   mem_readdata    32  read data, valid in the cycle waitrequest is low
//   mem_waitrequest  1  slave stall
// Modports: master (operand_fetch side), slave (memory / bus side).
interface operand_fetch_if;

    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    modport master (
        output mem_address,
        output mem_read,
        input  mem_readdata,
        input  mem_waitrequest
    );

    modport slave (
        input  mem_address,
        input  mem_read,
        output mem_readdata,
        output mem_waitrequest
    );

endinterface

// File: rtl/operand_fetch_rk_addr_gen.sv
// rk_addr_gen: combinational RK(x) address generator.
//   field    in   9  decoded operand field; bit ISK_BIT selects constant table
//   base     in  32  byte address of R(0)
//   k        in  32  byte address of K(0)
//   val_addr out 32  byte address of the TValue value word
//   tag_addr out 32  byte address of the TValue tt_ word (val_addr + 4)
// Arithmetic is 32-bit and wraps silently.
module rk_addr_gen #(
    parameter int unsigned TV_STRIDE = lua_cpu_pkg::TV_STRIDE
) (
    input  logic [8:0]  field,
    input  logic [31:0] base,
    input  logic [31:0] k,
    output logic [31:0] val_addr,
    output logic [31:0] tag_addr
);
    import lua_cpu_pkg::*;

    logic [31:0] offset;
    logic [31:0] origin;

    always_comb begin
        offset   = 32'(field[7:0]) * TV_STRIDE;
        origin   = field[ISK_BIT] ? k : base;
        val_addr = origin + offset;
        tag_addr = val_addr + 32'd4;
    end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: fetches RK(B) and RK(C) TValues for the execute stage.
//   clk, rst               clock, asynchronous active-high reset
//   mem                    Avalon master (operand_fetch_if.master); all-zero when idle so it
//                          can be OR-ed onto the shared bus
//   fetch_regs             level request, held until done
//   need_b, need_c         operand required by the opcode
//   B, C                   decoded fields (bit 8 = ISK)
//   base, k                byte addresses of R(0) and K(0)
//   data_b/type_b, data_c/type_c  captured value word and tag, held until overwritten
//   done                   one-cycle completion pulse
// Optional build macro OPERAND_FETCH_A_EN adds need_a, A, data_a, type_a and an R(A) fetch
// ahead of B.
module operand_fetch #(
    parameter int unsigned TV_STRIDE = lua_cpu_pkg::TV_STRIDE,
    parameter int unsigned TAG_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    operand_fetch_if.master   mem,
    input  logic              fetch_regs,
    input  logic              need_b,
    input  logic              need_c,
    input  logic [8:0]        B,
    input  logic [8:0]        C,
    input  logic [31:0]       base,
    input  logic [31:0]       k,
`ifdef OPERAND_FETCH_A_EN
    input  logic              need_a,
    input  logic [7:0]        A,
    output logic [31:0]       data_a,
    output logic [TAG_W-1:0]  type_a,
`endif
    output logic [31:0]       data_b,
    output logic [TAG_W-1:0]  type_b,
    output logic [31:0]       data_c,
    output logic [TAG_W-1:0]  type_c,
    output logic              done
);
    import lua_cpu_pkg::*;

    of_state_e state_q, state_d;

    logic [31:0]      data_b_q, data_b_d, data_c_q, data_c_d;
    logic [TAG_W-1:0] type_b_q, type_b_d, type_c_q, type_c_d;
    logic [31:0]      b_val_addr, b_tag_addr, c_val_addr, c_tag_addr;
    logic             rd;
    logic [31:0]      addr;
    logic             want_a;

    rk_addr_gen #(.TV_STRIDE(TV_STRIDE)) u_addr_b (
        .field    (B),
        .base     (base),
        .k        (k),
        .val_addr (b_val_addr),
        .tag_addr (b_tag_addr)
    );

    rk_addr_gen #(.TV_STRIDE(TV_STRIDE)) u_addr_c (
        .field    (C),
        .base     (base),
        .k        (k),
        .val_addr (c_val_addr),
        .tag_addr (c_tag_addr)
    );

`ifdef OPERAND_FETCH_A_EN
    logic [31:0]      data_a_q, data_a_d;
    logic [TAG_W-1:0] type_a_q, type_a_d;
    logic [31:0]      a_val_addr, a_tag_addr;

    // R(A) is always a stack register, so the ISK bit is forced low
    rk_addr_gen #(.TV_STRIDE(TV_STRIDE)) u_addr_a (
        .field    ({1'b0, A}),
        .base     (base),
        .k        (k),
        .val_addr (a_val_addr),
        .tag_addr (a_tag_addr)
    );

    assign want_a = need_a;
    assign data_a = data_a_q;
    assign type_a = type_a_q;
`else
    assign want_a = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rd       = 1'b0;
        addr     = '0;
        data_b_d = data_b_q;
        type_b_d = type_b_q;
        data_c_d = data_c_q;
        type_c_d = type_c_q;
`ifdef OPERAND_FETCH_A_EN
        data_a_d = data_a_q;
        type_a_d = type_a_q;
`endif
        // Dropping fetch_regs only takes effect at a word boundary: the read in flight
        // stays asserted until accepted, then the FSM returns to idle without done.
        unique case (state_q)
            StIdle: begin
                if (fetch_regs) state_d = of_first_state(want_a, need_b, need_c);
            end
`ifdef OPERAND_FETCH_A_EN
            StAVal: begin
                rd   = 1'b1;
                addr = a_val_addr;
                if (!mem.mem_waitrequest) begin
                    data_a_d = mem.mem_readdata;
                    state_d  = fetch_regs ? StATt : StIdle;
                end
            end
            StATt: begin
                rd   = 1'b1;
                addr = a_tag_addr;
                if (!mem.mem_waitrequest) begin
                    type_a_d = mem.mem_readdata[TAG_W-1:0];
                    state_d  = fetch_regs ? of_first_state(1'b0, need_b, need_c) : StIdle;
                end
            end
`endif
            StBVal: begin
                rd   = 1'b1;
                addr = b_val_addr;
                if (!mem.mem_waitrequest) begin
                    data_b_d = mem.mem_readdata;
                    state_d  = fetch_regs ? StBTt : StIdle;
                end
            end
            StBTt: begin
                rd   = 1'b1;
                addr = b_tag_addr;
                if (!mem.mem_waitrequest) begin
                    type_b_d = mem.mem_readdata[TAG_W-1:0];
                    state_d  = fetch_regs ? of_first_state(1'b0, 1'b0, need_c) : StIdle;
                end
            end
            StCVal: begin
                rd   = 1'b1;
                addr = c_val_addr;
                if (!mem.mem_waitrequest) begin
                    data_c_d = mem.mem_readdata;
                    state_d  = fetch_regs ? StCTt : StIdle;
                end
            end
            StCTt: begin
                rd   = 1'b1;
                addr = c_tag_addr;
                if (!mem.mem_waitrequest) begin
                    type_c_d = mem.mem_readdata[TAG_W-1:0];
                    state_d  = fetch_regs ? StDone : StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            data_b_q <= '0;
            type_b_q <= '0;
            data_c_q <= '0;
            type_c_q <= '0;
`ifdef OPERAND_FETCH_A_EN
            data_a_q <= '0;
            type_a_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            data_b_q <= data_b_d;
            type_b_q <= type_b_d;
            data_c_q <= data_c_d;
            type_c_q <= type_c_d;
`ifdef OPERAND_FETCH_A_EN
            data_a_q <= data_a_d;
            type_a_q <= type_a_d;
`endif
        end
    end

    // Bus strobes decode from the registered state only, so reset clears them at once
    assign mem.mem_read    = rd;
    assign mem.mem_address = addr;
    assign done            = (state_q == StDone);
    assign data_b          = data_b_q;
    assign type_b          = type_b_q;
    assign data_c          = data_c_q;
    assign type_c          = type_c_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
    import lua_cpu_pkg::*;

    localparam int unsigned TAG_W = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_regs = 1'b0, need_b = 1'b0, need_c = 1'b0;
    logic [8:0]  B = '0, C = '0;
    logic [31:0] base = '0, k = '0;
    logic [31:0] data_b, data_c;
    logic [TAG_W-1:0] type_b, type_c;
    logic        done;
`ifdef OPERAND_FETCH_A_EN
    logic        need_a = 1'b0;
    logic [7:0]  A = '0;
    logic [31:0] data_a;
    logic [TAG_W-1:0] type_a;
`endif

    operand_fetch_if bus ();

    operand_fetch #(.TV_STRIDE(8), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (bus.master),
        .fetch_regs (fetch_regs),
        .need_b     (need_b),
        .need_c     (need_c),
        .B          (B),
        .C          (C),
        .base       (base),
        .k          (k),
`ifdef OPERAND_FETCH_A_EN
        .need_a     (need_a),
        .A          (A),
        .data_a     (data_a),
        .type_a     (type_a),
`endif
        .data_b     (data_b),
        .type_b     (type_b),
        .data_c     (data_c),
        .type_c     (type_c),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory image: deterministic hash of the byte address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    function automatic logic [TAG_W-1:0] mem_tag(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return w[TAG_W-1:0];
    endfunction

    function automatic logic [31:0] rk_addr(input logic [8:0] x, input logic [31:0] bs,
                                            input logic [31:0] kk);
        logic [31:0] off;
        off = {21'b0, x[7:0], 3'b000};
        return (x[8] ? kk : bs) + off;
    endfunction

    // Slave model: wait_cfg stall cycles in front of every word
    int wait_cfg  = 0;
    int wait_left = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) wait_left <= wait_cfg;
        else if (!bus.mem_read) wait_left <= wait_cfg;
        else if (wait_left != 0) wait_left <= wait_left - 1;
        else wait_left <= wait_cfg;
    end
    assign bus.mem_waitrequest = bus.mem_read && (wait_left != 0);
    assign bus.mem_readdata    = bus.mem_read ? mem_word(bus.mem_address) : 32'h0;

    // Bus monitor: logs accepted addresses and protocol violations
    logic [31:0] obs_q[$];
    int          nz_cnt = 0;
    int          hold_viol = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    always @(negedge clk) begin
        if (bus.mem_read && !bus.mem_waitrequest) obs_q.push_back(bus.mem_address);
        if (!bus.mem_read && bus.mem_address != 32'h0) nz_cnt <= nz_cnt + 1;
        if (prev_hold && bus.mem_read && bus.mem_address != prev_addr)
            hold_viol <= hold_viol + 1;
        prev_hold <= bus.mem_read && bus.mem_waitrequest;
        prev_addr <= bus.mem_address;
    end

    logic [31:0]      exp_q[$];
    logic [31:0]      m_data_b = '0, m_data_c = '0;
    logic [TAG_W-1:0] m_type_b = '0, m_type_c = '0;

    // Called #1 after a posedge; returns cycles until done (-1 on timeout), drops fetch_regs
    task automatic run_fetch(output int cyc);
        bit got;
        got = 0;
        cyc = 0;
        fetch_regs = 1'b1;
        while (!got && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (done) got = 1;
        end
        fetch_regs = 1'b0;
        if (!got) cyc = -1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (bus.mem_read !== 1'b0) $display("FAIL reset_read got %b want 0", bus.mem_read); else n_pass++;
        n_checks++; if (bus.mem_address !== 32'h0) $display("FAIL reset_addr got %h want 0", bus.mem_address); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_checks++; if ({data_b, data_c} !== 64'h0) $display("FAIL reset_data got %h %h want 0", data_b, data_c); else n_pass++;
        n_checks++; if ({type_b, type_c} !== '0) $display("FAIL reset_type got %h %h want 0", type_b, type_c); else n_pass++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_register_operands();
        int cyc, i0;
        logic [31:0] e, g;
        wait_cfg = 0; base = 32'h1000; k = 32'h9000; B = 9'd3; C = 9'd4;
        need_b = 1'b1; need_c = 1'b1;
        exp_q.push_back(32'h1018); exp_q.push_back(32'h101C);
        exp_q.push_back(32'h1020); exp_q.push_back(32'h1024);
        m_data_b = mem_word(32'h1018); m_type_b = mem_tag(32'h101C);
        m_data_c = mem_word(32'h1020); m_type_c = mem_tag(32'h1024);
        i0 = obs_q.size();
        run_fetch(cyc);
        n_checks++; if (cyc != 5) $display("FAIL reg_latency got %0d want 5", cyc); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            g = (i0 + i < obs_q.size()) ? obs_q[i0 + i] : 32'hDEAD_BEEF;
            e = exp_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL reg_addr%0d got %h want %h", i, g, e); else n_pass++;
        end
        n_checks++; if (data_b !== m_data_b || type_b !== m_type_b) $display("FAIL reg_b got %h/%h want %h/%h", data_b, type_b, m_data_b, m_type_b); else n_pass++;
        n_checks++; if (data_c !== m_data_c || type_c !== m_type_c) $display("FAIL reg_c got %h/%h want %h/%h", data_c, type_c, m_data_c, m_type_c); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) $display("FAIL reg_done_pulse got %b want 0", done); else n_pass++;
    endtask

    task automatic test_constant();
        int cyc, i0;
        logic [31:0] e, g;
        k = 32'h2000; C = 9'h105; need_b = 1'b0; need_c = 1'b1;
        exp_q.push_back(32'h2028); exp_q.push_back(32'h202C);
        m_data_c = mem_word(32'h2028); m_type_c = mem_tag(32'h202C);
        i0 = obs_q.size();
        run_fetch(cyc);
        n_checks++; if (cyc != 3) $display("FAIL const_latency got %0d want 3", cyc); else n_pass++;
        n_checks++; if (obs_q.size() - i0 != 2) $display("FAIL const_nwords got %0d want 2", obs_q.size() - i0); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            g = (i0 + i < obs_q.size()) ? obs_q[i0 + i] : 32'hDEAD_BEEF;
            e = exp_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL const_addr%0d got %h want %h", i, g, e); else n_pass++;
        end
        n_checks++; if (data_c !== m_data_c || type_c !== m_type_c) $display("FAIL const_c got %h/%h want %h/%h", data_c, type_c, m_data_c, m_type_c); else n_pass++;
        n_checks++; if (data_b !== m_data_b || type_b !== m_type_b) $display("FAIL const_b_kept got %h/%h want %h/%h", data_b, type_b, m_data_b, m_type_b); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_wait_states();
        int cyc, i0, hv0;
        logic [31:0] e, g;
        wait_cfg = 3; base = 32'h0000_4000; k = 32'h0000_8000; B = 9'h007; C = 9'h110;
        need_b = 1'b1; need_c = 1'b1;
        exp_q.push_back(rk_addr(B, base, k)); exp_q.push_back(rk_addr(B, base, k) + 4);
        exp_q.push_back(rk_addr(C, base, k)); exp_q.push_back(rk_addr(C, base, k) + 4);
        m_data_b = mem_word(rk_addr(B, base, k)); m_type_b = mem_tag(rk_addr(B, base, k) + 4);
        m_data_c = mem_word(rk_addr(C, base, k)); m_type_c = mem_tag(rk_addr(C, base, k) + 4);
        i0 = obs_q.size(); hv0 = hold_viol;
        run_fetch(cyc);
        n_checks++; if (cyc != 17) $display("FAIL wait_latency got %0d want 17", cyc); else n_pass++;
        n_checks++; if (hold_viol != hv0) $display("FAIL wait_hold got %0d changes want 0", hold_viol - hv0); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            g = (i0 + i < obs_q.size()) ? obs_q[i0 + i] : 32'hDEAD_BEEF;
            e = exp_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL wait_addr%0d got %h want %h", i, g, e); else n_pass++;
        end
        n_checks++; if (data_b !== m_data_b || type_b !== m_type_b) $display("FAIL wait_b got %h/%h want %h/%h", data_b, type_b, m_data_b, m_type_b); else n_pass++;
        n_checks++; if (data_c !== m_data_c || type_c !== m_type_c) $display("FAIL wait_c got %h/%h want %h/%h", data_c, type_c, m_data_c, m_type_c); else n_pass++;
        wait_cfg = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_empty();
        int cyc, i0;
        need_b = 1'b0; need_c = 1'b0;
        i0 = obs_q.size();
        run_fetch(cyc);
        n_checks++; if (cyc != 1) $display("FAIL empty_latency got %0d want 1", cyc); else n_pass++;
        n_checks++; if (obs_q.size() != i0) $display("FAIL empty_reads got %0d want 0", obs_q.size() - i0); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) $display("FAIL empty_done_pulse got %b want 0", done); else n_pass++;
        n_checks++; if (data_b !== m_data_b || data_c !== m_data_c) $display("FAIL empty_kept got %h %h want %h %h", data_b, data_c, m_data_b, m_data_c); else n_pass++;
    endtask

    task automatic test_wrap();
        int cyc, i0;
        logic [31:0] e, g;
        base = 32'hFFFF_FFF8; B = 9'd1; need_b = 1'b1; need_c = 1'b0;
        exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_0004);
        m_data_b = mem_word(32'h0); m_type_b = mem_tag(32'h4);
        i0 = obs_q.size();
        run_fetch(cyc);
        n_checks++; if (cyc != 3) $display("FAIL wrap_latency got %0d want 3", cyc); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            g = (i0 + i < obs_q.size()) ? obs_q[i0 + i] : 32'hDEAD_BEEF;
            e = exp_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL wrap_addr%0d got %h want %h", i, g, e); else n_pass++;
        end
        n_checks++; if (data_b !== m_data_b || type_b !== m_type_b) $display("FAIL wrap_b got %h/%h want %h/%h", data_b, type_b, m_data_b, m_type_b); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int i0, cnt;
        bit saw_done;
        logic [31:0] e, g;
        wait_cfg = 2; base = 32'h0000_3000; B = 9'h00A; C = 9'h00B;
        need_b = 1'b1; need_c = 1'b1;
        exp_q.push_back(rk_addr(B, base, k));
        m_data_b = mem_word(rk_addr(B, base, k));
        i0 = obs_q.size();
        fetch_regs = 1'b1;
        @(posedge clk); #1;
        fetch_regs = 1'b0;
        n_checks++; if (bus.mem_read !== 1'b1) $display("FAIL abort_read_held got %b want 1", bus.mem_read); else n_pass++;
        saw_done = 0;
        for (cnt = 0; cnt < 10; cnt++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1;
        end
        n_checks++; if (saw_done) $display("FAIL abort_no_done got 1 want 0"); else n_pass++;
        n_checks++; if (obs_q.size() - i0 != 1) $display("FAIL abort_nwords got %0d want 1", obs_q.size() - i0); else n_pass++;
        g = (i0 < obs_q.size()) ? obs_q[i0] : 32'hDEAD_BEEF;
        e = exp_q.pop_front();
        n_checks++; if (g !== e) $display("FAIL abort_addr got %h want %h", g, e); else n_pass++;
        n_checks++; if (data_b !== m_data_b || type_b !== m_type_b) $display("FAIL abort_b got %h/%h want %h/%h", data_b, type_b, m_data_b, m_type_b); else n_pass++;
        n_checks++; if (data_c !== m_data_c || type_c !== m_type_c) $display("FAIL abort_c_kept got %h/%h want %h/%h", data_c, type_c, m_data_c, m_type_c); else n_pass++;
        wait_cfg = 0;
    endtask

    task automatic test_back_to_back();
        int cyc, gap, i0;
        bit got;
        logic [31:0] e, g;
        base = 32'h0000_5000; B = 9'd2; need_b = 1'b1; need_c = 1'b0;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(rk_addr(B, base, k)); exp_q.push_back(rk_addr(B, base, k) + 4);
        end
        m_data_b = mem_word(rk_addr(B, base, k)); m_type_b = mem_tag(rk_addr(B, base, k) + 4);
        i0 = obs_q.size();
        fetch_regs = 1'b1;
        cyc = 0; got = 0;
        while (!got && cyc < 50) begin
            @(posedge clk); #1; cyc++;
            if (done) got = 1;
        end
        n_checks++; if (!got || cyc != 3) $display("FAIL b2b_first got %0d want 3", got ? cyc : -1); else n_pass++;
        gap = 0; got = 0;
        while (!got && gap < 50) begin
            @(posedge clk); #1; gap++;
            if (done) got = 1;
        end
        fetch_regs = 1'b0;
        n_checks++; if (!got || gap != 4) $display("FAIL b2b_gap got %0d want 4", got ? gap : -1); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            g = (i0 + i < obs_q.size()) ? obs_q[i0 + i] : 32'hDEAD_BEEF;
            e = exp_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL b2b_addr%0d got %h want %h", i, g, e); else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int cnt, cyc, i0;
        bit found;
        logic [31:0] tag_a, g;
        wait_cfg = 10; base = 32'h0000_6000; B = 9'd5; need_b = 1'b1; need_c = 1'b0;
        tag_a = rk_addr(B, base, k) + 4;
        fetch_regs = 1'b1;
        found = 0;
        for (cnt = 0; cnt < 40 && !found; cnt++) begin
            @(posedge clk); #1;
            if (bus.mem_read && bus.mem_address == tag_a) found = 1;
        end
        n_checks++; if (!found) $display("FAIL rstmid_reach_btt got 0 want 1"); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.mem_read !== 1'b0 || bus.mem_address !== 32'h0) $display("FAIL rstmid_bus got %b/%h want 0/0", bus.mem_read, bus.mem_address); else n_pass++;
        n_checks++; if ({data_b, data_c} !== 64'h0 || {type_b, type_c} !== '0 || done !== 1'b0) $display("FAIL rstmid_outputs got %h %h %h %h %b want 0", data_b, data_c, type_b, type_c, done); else n_pass++;
        fetch_regs = 1'b0;
        wait_cfg = 0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        m_data_b = mem_word(rk_addr(B, base, k)); m_type_b = mem_tag(tag_a);
        i0 = obs_q.size();
        run_fetch(cyc);
        n_checks++; if (cyc != 3) $display("FAIL rstmid_restart_latency got %0d want 3", cyc); else n_pass++;
        g = (i0 < obs_q.size()) ? obs_q[i0] : 32'hDEAD_BEEF;
        n_checks++; if (g !== rk_addr(B, base, k)) $display("FAIL rstmid_restart_addr got %h want %h", g, rk_addr(B, base, k)); else n_pass++;
        n_checks++; if (data_b !== m_data_b || type_b !== m_type_b) $display("FAIL rstmid_b got %h/%h want %h/%h", data_b, type_b, m_data_b, m_type_b); else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_register_operands();
        test_constant();
        test_wait_states();
        test_empty();
        test_wrap();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        n_checks++; if (nz_cnt != 0) $display("FAIL idle_addr_zero got %0d violations want 0", nz_cnt); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Downstream neighbour of the decoder; implements the EX_FETCH_REGS step of the sequencer.
- From the decoded B/C fields, fetches the two Lua operands (RK(B), RK(C)) as TValues from the Lua stack or constant table over the shared Avalon master.
- Presents value and type tag to the execute stage.
- Its memory signals are zero when idle, so they OR into the shared master bus alongside the PC and IR ports.

Parameters:
- TV_STRIDE, 8, bytes per TValue in memory (word 0 = value, word 1 = tt_).
- TAG_W, 6, width of the type tag output (tt_ bits [TAG_W-1:0]).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mem_address  out  32  Avalon master address (0 when not reading)
- mem_readdata  in  32  Avalon read data
- mem_read  out  1  Avalon read strobe
- mem_waitrequest  in  1  Avalon wait request
- fetch_regs  in  1  level request from the sequencer; held until done is seen
- need_b  in  1  operand B required by the opcode
- need_c  in  1  operand C required by the opcode
- B  in  9  decoded B field; bit 8 = ISK
- C  in  9  decoded C field; bit 8 = ISK
- base  in  32  byte address of R(0) (ci->u.l.base)
- k  in  32  byte address of K(0) (proto->k)
- data_b  out  32  value word of RK(B)
- type_b  out  TAG_W  tag of RK(B)
- data_c  out  32  value word of RK(C)
- type_c  out  TAG_W  tag of RK(C)
- done  out  1  one-cycle completion pulse

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high. Reset drives all outputs to 0 and the state to IDLE.
- Address generation, 32-bit with wrap-around, no overflow detection:
  - x[8]=0: addr = base + x[7:0]*TV_STRIDE.
  - x[8]=1: addr = k + x[7:0]*TV_STRIDE.
  - Tag word is at addr+4.
- State machine: IDLE, B_VAL, B_TT, C_VAL, C_TT, DONE.
  - IDLE: on fetch_regs=1, go to B_VAL if need_b, else C_VAL if need_c, else DONE.
  - X_VAL: mem_read=1, mem_address=addr. On waitrequest=0, capture readdata into data_x and go to X_TT.
  - X_TT: reads addr+4. On waitrequest=0, capture readdata[TAG_W-1:0] into type_x.
    - From B_TT: go to C_VAL if need_c, else DONE.
    - From C_TT: go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Read data is valid in the same cycle waitrequest is low (zero read latency). Each word costs at least one cycle.
- Minimum latency with no wait states: 5 cycles from the fetch_regs rising edge to done (both operands); 3 cycles with one operand; 1 cycle with none (done in the cycle after start, no bus access).
- B, C, need_b, need_c, base and k must stay stable while fetch_regs is high. Addresses are computed combinationally from them.
- data_*/type_* hold their last captured values until overwritten. Operands that are not needed are not modified.
- fetch_regs dropped mid-operation: the current word transfer completes, because mem_read stays asserted until waitrequest is low. The block then returns to IDLE without pulsing done; captured data is kept.
- fetch_regs still high in IDLE after DONE: treated as a new request.
- Reset mid-transfer: mem_read drops immediately (asynchronous) and state goes to IDLE.
- mem_address is 0 whenever mem_read=0.

Optional Feature:
- Macro: OPERAND_FETCH_A_EN.
- Defined:
  - Adds ports need_a (in 1), A (in 8), data_a (out 32), type_a (out TAG_W), and states A_VAL/A_TT ahead of B_VAL.
  - R(A) is always a register (base + A*TV_STRIDE), never a constant.
  - Used by SETTABLE/TEST-style opcodes.
- Undefined: these ports and states do not exist; the behaviour is as above.

Decomposition:
- Shared package lua_cpu_pkg:
  - TV_STRIDE and ISK_BIT (8).
  - Type tags T_NIL=0, T_BOOLEAN=1, T_NUMBER=3, T_STRING=4, T_TABLE=5, T_FUNCTION=6.
  - Opcode constants (shared with the sequencer).
  - Operand-fetch state encoding.
- One sub-module: rk_addr_gen, combinational (field, base, k -> value address, tag address). It is instantiated per operand.

Test Plan:
- Register operands: base=0x1000, B=3, C=4, need_b=need_c=1, no waits -> reads 0x1018, 0x101C, 0x1020, 0x1024 in consecutive cycles; done on cycle 5; data_b/type_b, data_c/type_c match memory.
- Constant operand: k=0x2000, C=0x105, need_b=0 -> reads only 0x2028, 0x202C; data_b unchanged; done on cycle 3.
- Wait states: waitrequest high for 3 cycles on each word -> mem_read/mem_address held constant throughout; done on cycle 17; captured values correct.
- Empty request: need_b=need_c=0 -> no mem_read; done is a one-cycle pulse in the cycle after fetch_regs rises.
- Wrap-around: base=0xFFFFFFF8, B=1 -> addresses 0x00000000 and 0x00000004.
- Reset during B_TT with waitrequest high -> mem_read=0 and all outputs 0 immediately; a subsequent fetch restarts at B_VAL.
